dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-cycle data memory between the CPU load/store path (port 0) and a second master such as a program loader, DMA or debug port (port 1). It sits between the requesters and the data memory instance. It grants at most one access per cycle, using round-robin fairness and an optional bounded burst lock. It registers read data so each requester sees a one-cycle read response.

---
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the shared single-cycle data memory, with
// bounded burst locking and a registered one-cycle read response per port.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [2:0]            mode0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  lock0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [2:0]            mode1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  lock1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_we,
  output logic [2:0]            mem_mode,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);

  logic          last;
  logic          own_v;
  logic          own;
  logic [CW-1:0] cnt;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       own_req;
  logic       other_req;
  logic       any_gnt;
  logic       gsel;
  logic       glock;

  assign req       = {req1, req0};
  assign own_req   = own ? req1 : req0;
  assign other_req = own ? req0 : req1;

  // A held lock wins until the burst budget runs out while the other port waits.
  always_comb begin
    gnt = 2'b00;
    if (own_v && own_req && ((cnt < CW'(MAX_BURST)) || !other_req)) begin
      gnt = own ? 2'b10 : 2'b01;
    end else if (req == 2'b01 || req == 2'b10) begin
      gnt = req;
    end else if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign any_gnt = gnt[0] | gnt[1];
  assign gsel    = gnt[1];
  assign glock   = gsel ? lock1 : lock0;

  assign mem_we    = any_gnt & (gsel ? we1 : we0);
  assign mem_mode  = !any_gnt ? 3'b000 : (gsel ? mode1 : mode0);
  assign mem_addr  = !any_gnt ? '0 : (gsel ? addr1 : addr0);
  assign mem_wdata = !any_gnt ? '0 : (gsel ? wdata1 : wdata0);

  // Fairness and ownership tracking; a non-locking beat or a dropped owner request ends the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last  <= 1'b1;
      own_v <= 1'b0;
      own   <= 1'b0;
      cnt   <= '0;
    end else if (any_gnt) begin
      last <= gsel;
      if (glock) begin
        own_v <= 1'b1;
        own   <= gsel;
        if (own_v && (own == gsel)) begin
          cnt <= (cnt == CW'(MAX_BURST)) ? cnt : cnt + CW'(1);
        end else begin
          cnt <= CW'(1);
        end
      end else begin
        own_v <= 1'b0;
        cnt   <= '0;
      end
    end else if (own_v && !own_req) begin
      own_v <= 1'b0;
      cnt   <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt[0] & !we0;
      rvalid1 <= gnt[1] & !we1;
      if (gnt[0] && !we0) rdata0 <= mem_rdata;
      if (gnt[1] && !we1) rdata1 <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table from reset plus hand-written
// sequences for round-robin, burst lock, saturation and reset mid-burst.
module tb_dmem_arbiter;

  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'h0000_0040;
  localparam logic [31:0] W0 = 32'hA5A5_0000;
  localparam logic [31:0] W1 = 32'h1234_5678;
  localparam logic [2:0]  M0 = 3'b010;
  localparam logic [2:0]  M1 = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
  logic        req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [2:0]  mode0 = M0, mode1 = M1;
  logic [31:0] addr0 = A0, addr1 = A1, wdata0 = W0, wdata1 = W1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic [2:0]  mem_mode;
  logic [31:0] mem_rdata = 32'h0;

  int tests = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  lock;
    logic [31:0] rd;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
  } vec_t;

  vec_t vecs[15];

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .mode0(mode0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .req1(req1), .we1(we1), .mode1(mode1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rdata0(rdata0), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                               input logic [31:0] rd);
    @(negedge clk);
    req0 = r[0]; req1 = r[1];
    we0 = w[0]; we1 = w[1];
    lock0 = l[0]; lock1 = l[1];
    mem_rdata = rd;
  endtask

  // Expected memory-side values follow from whichever port the bench expects to win.
  task automatic checkComb(input string tag, input logic [1:0] g, input logic [1:0] w);
    logic        ew;
    logic [31:0] ea, ed;
    logic [2:0]  em;
    #1;
    ew = g[0] ? w[0] : (g[1] ? w[1] : 1'b0);
    ea = g[0] ? A0 : (g[1] ? A1 : 32'h0);
    ed = g[0] ? W0 : (g[1] ? W1 : 32'h0);
    em = g[0] ? M0 : (g[1] ? M1 : 3'b000);
    checkOutput({tag, " gnt0"}, {31'b0, gnt0}, {31'b0, g[0]});
    checkOutput({tag, " gnt1"}, {31'b0, gnt1}, {31'b0, g[1]});
    checkOutput({tag, " mem_we"}, {31'b0, mem_we}, {31'b0, ew});
    checkOutput({tag, " mem_addr"}, mem_addr, ea);
    checkOutput({tag, " mem_wdata"}, mem_wdata, ed);
    checkOutput({tag, " mem_mode"}, {29'b0, mem_mode}, {29'b0, em});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{2'b00, 2'b00, 2'b00, 32'h0000_0000, 2'b00, 2'b00, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{2'b01, 2'b00, 2'b00, 32'hDEAD_BEEF, 2'b01, 2'b01, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[2]  = '{2'b11, 2'b00, 2'b00, 32'h1111_1111, 2'b10, 2'b10, 32'hDEAD_BEEF, 32'h1111_1111};
    vecs[3]  = '{2'b11, 2'b00, 2'b00, 32'h2222_2222, 2'b01, 2'b01, 32'h2222_2222, 32'h1111_1111};
    vecs[4]  = '{2'b11, 2'b00, 2'b00, 32'h3333_3333, 2'b10, 2'b10, 32'h2222_2222, 32'h3333_3333};
    vecs[5]  = '{2'b11, 2'b00, 2'b00, 32'h4444_4444, 2'b01, 2'b01, 32'h4444_4444, 32'h3333_3333};
    vecs[6]  = '{2'b10, 2'b10, 2'b00, 32'h0BAD_F00D, 2'b10, 2'b00, 32'h4444_4444, 32'h3333_3333};
    vecs[7]  = '{2'b11, 2'b00, 2'b01, 32'h5555_5555, 2'b01, 2'b01, 32'h5555_5555, 32'h3333_3333};
    vecs[8]  = '{2'b11, 2'b00, 2'b01, 32'h6666_6666, 2'b01, 2'b01, 32'h6666_6666, 32'h3333_3333};
    vecs[9]  = '{2'b11, 2'b00, 2'b01, 32'h7777_7777, 2'b01, 2'b01, 32'h7777_7777, 32'h3333_3333};
    vecs[10] = '{2'b11, 2'b00, 2'b01, 32'h8888_8888, 2'b01, 2'b01, 32'h8888_8888, 32'h3333_3333};
    vecs[11] = '{2'b11, 2'b00, 2'b01, 32'h9999_9999, 2'b10, 2'b10, 32'h8888_8888, 32'h9999_9999};
    vecs[12] = '{2'b11, 2'b00, 2'b01, 32'hAAAA_AAAA, 2'b01, 2'b01, 32'hAAAA_AAAA, 32'h9999_9999};
    vecs[13] = '{2'b10, 2'b00, 2'b01, 32'hBBBB_BBBB, 2'b10, 2'b10, 32'hAAAA_AAAA, 32'hBBBB_BBBB};
    vecs[14] = '{2'b00, 2'b00, 2'b00, 32'hCCCC_CCCC, 2'b00, 2'b00, 32'hAAAA_AAAA, 32'hBBBB_BBBB};

    // Reset state
    doReset();
    #1;
    checkOutput("reset gnt0", {31'b0, gnt0}, 32'h0);
    checkOutput("reset gnt1", {31'b0, gnt1}, 32'h0);
    checkOutput("reset rvalid0", {31'b0, rvalid0}, 32'h0);
    checkOutput("reset rvalid1", {31'b0, rvalid1}, 32'h0);
    checkOutput("reset rdata0", rdata0, 32'h0);
    checkOutput("reset rdata1", rdata1, 32'h0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);

    // Vector table, applied in order from reset
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].req, vecs[i].we, vecs[i].lock, vecs[i].rd);
      checkComb($sformatf("v%0d", i), vecs[i].gnt, vecs[i].we);
      tick();
      checkOutput($sformatf("v%0d rvalid0", i), {31'b0, rvalid0}, {31'b0, vecs[i].rvalid[0]});
      checkOutput($sformatf("v%0d rvalid1", i), {31'b0, rvalid1}, {31'b0, vecs[i].rvalid[1]});
      checkOutput($sformatf("v%0d rdata0", i), rdata0, vecs[i].rdata0);
      checkOutput($sformatf("v%0d rdata1", i), rdata1, vecs[i].rdata1);
    end

    // Round-robin from reset: 0,1,0,1
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, 2'b00, 2'b00, 32'h0000_1000 + i);
      checkComb($sformatf("rr%0d", i), (i % 2 == 0) ? 2'b01 : 2'b10, 2'b00);
      tick();
    end

    // Lone locked requester saturates and keeps the grant, then hands off at once
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b01, 2'b01, 2'b01, 32'h0);
      checkComb($sformatf("sat%0d", i), 2'b01, 2'b01);
      tick();
      checkOutput($sformatf("sat%0d own_v", i), {31'b0, dut.own_v}, 32'h1);
    end
    checkOutput("sat cnt", 32'(dut.cnt), 32'd4);
    applyStimulus(2'b11, 2'b01, 2'b01, 32'hFEED_0001);
    checkComb("sat handoff", 2'b10, 2'b01);
    tick();
    checkOutput("sat handoff own_v", {31'b0, dut.own_v}, 32'h0);
    checkOutput("sat handoff rvalid1", {31'b0, rvalid1}, 32'h1);
    checkOutput("sat handoff rdata1", rdata1, 32'hFEED_0001);

    // Both ports locking: four beats each, then ownership returns to port 0
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(2'b11, 2'b11, 2'b11, 32'h0);
      checkComb($sformatf("dual%0d", i), (i >= 4 && i < 8) ? 2'b10 : 2'b01, 2'b11);
      tick();
    end

    // Reset mid-burst on port 1 with a load granted: no rvalid, lock cleared
    doReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(2'b10, 2'b10, 2'b10, 32'h0);
      checkComb($sformatf("rstb%0d", i), 2'b10, 2'b10);
      tick();
    end
    applyStimulus(2'b10, 2'b00, 2'b10, 32'h5A5A_5A5A);
    checkComb("rstb load", 2'b10, 2'b00);
    rst = 1'b1;
    tick();
    checkOutput("rstb rvalid1", {31'b0, rvalid1}, 32'h0);
    checkOutput("rstb rdata1", rdata1, 32'h0);
    checkOutput("rstb own_v", {31'b0, dut.own_v}, 32'h0);
    checkOutput("rstb cnt", 32'(dut.cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    mem_rdata = 32'h0C0F_FEE0;
    checkComb("rstb post", 2'b01, 2'b00);
    tick();
    checkOutput("rstb post rvalid0", {31'b0, rvalid0}, 32'h1);
    checkOutput("rstb post rvalid1", {31'b0, rvalid1}, 32'h0);
    checkOutput("rstb post rdata0", rdata0, 32'h0C0F_FEE0);

    // Idle cycles
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00, 2'b00, 2'b00, 32'hFFFF_FFFF);
      checkComb($sformatf("idle%0d", i), 2'b00, 2'b00);
      tick();
      checkOutput($sformatf("idle%0d rvalid0", i), {31'b0, rvalid0}, 32'h0);
      checkOutput($sformatf("idle%0d rvalid1", i), {31'b0, rvalid1}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
